ro_scan_ctrl: RTL and testbench

Measurement sequencer for the RO2 reliability-sensor peripheral: scans a bank of ring oscillators one at a time through a single shared edge counter. Enables the selected oscillator, waits a settle time, counts synchronized oscillator pulses over a programmable gate window, then hands the count to the AXI4-Lite register bank over a valid/ready handshake. Sits between the AXI slave register bank (configuration, results) and the ring-oscillator array (enables, pulse input).

---
 rtl/ro_scan_pkg.sv | 25 ++
 rtl/ro_scan_next_bit.sv | 26 ++
 rtl/ro_scan_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ro_scan_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_scan_pkg.sv
// Shared definitions for the ring-oscillator scan sequencer. The register bank
// imports this too, so the state encoding below doubles as the status readback.
package ro_scan_pkg;

    // Defaults used when the parent does not override the sequencer parameters.
    localparam int unsigned DEF_SETTLE_CYC = 16;
    localparam int unsigned DEF_WIN_W      = 24;

    // Sequencer state encoding, kept as plain constants so older blocks that
    // decode the status field as a raw 3-bit value stay compatible.
    typedef logic [2:0] scan_state_t;

    localparam scan_state_t StIdle   = 3'd0;
    localparam scan_state_t StSettle = 3'd1;
    localparam scan_state_t StGate   = 3'd2;
    localparam scan_state_t StLatch  = 3'd3;
    localparam scan_state_t StPush   = 3'd4;

    // Width of an index into n items; never narrower than one bit so a
    // single-oscillator build still has a legal select port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_scan_next_bit.sv
// Finds the lowest set mask bit strictly above a given index, or the lowest set
// bit overall when from_start is high. Purely combinational.
module ro_scan_next_bit #(
    parameter int unsigned NUM_RO = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [NUM_RO-1:0] mask,
    input  logic [IDX_W-1:0]  cur,
    input  logic              from_start,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    // Ascending scan; the first eligible bit wins and later ones are ignored.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (!found && mask[i] && (from_start || (i > 32'(cur)))) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan sequencer: walks the latched mask one oscillator at a
// time, settles it, counts synchronized pulses over the gate window and hands
// each count to the register bank over a valid/ready handshake.
module ro_scan_ctrl
    import ro_scan_pkg::*;
#(
    parameter int unsigned NUM_RO     = 8,
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned WIN_W      = DEF_WIN_W,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int unsigned IDX_W     = idx_width(NUM_RO)
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [NUM_RO-1:0]  cfg_mask,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               ro_pulse,
    output logic [NUM_RO-1:0]  ro_en,
    output logic [IDX_W-1:0]   ro_sel,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COUNT_W-1:0] res_data,
    output logic [IDX_W-1:0]   res_idx,
    output logic               res_sat,
    output logic               busy,
    output logic               done
);

    // One down-counter serves both the settle delay and the gate window, so it
    // must be wide enough for whichever of the two is larger.
    localparam int unsigned SET_W = idx_width(SETTLE_CYC);
    localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

    // Sequencer state
    scan_state_t        state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [NUM_RO-1:0]  mask_q, mask_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               sat_q, sat_d;

    // Registered outputs
    logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
    logic [IDX_W-1:0]   ro_sel_q, ro_sel_d;
    logic               res_valid_q, res_valid_d;
    logic [COUNT_W-1:0] res_data_q, res_data_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               res_sat_q, res_sat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-bit finder plumbing and helpers
    logic               nb_first;
    logic [NUM_RO-1:0]  nb_mask;
    logic               nb_found;
    logic [IDX_W-1:0]   nb_idx;
    logic [TMR_W-1:0]   gate_load;
    logic               scan_end;
    logic               en_next;

    // In IDLE the mask is not latched yet, so search the live config value;
    // afterwards search the latched mask above the current oscillator.
    assign nb_first = (state_q == StIdle);
    assign nb_mask  = nb_first ? cfg_mask : mask_q;

    // A zero window still opens the gate for one cycle.
    assign gate_load = (win_q == '0) ? '0 : TMR_W'(win_q - WIN_W'(1));

    ro_scan_next_bit #(
        .NUM_RO (NUM_RO),
        .IDX_W  (IDX_W)
    ) u_next_bit (
        .mask       (nb_mask),
        .cur        (cur_q),
        .from_start (nb_first),
        .found      (nb_found),
        .idx        (nb_idx)
    );

    // Sequencer next state, pulse counting and result capture.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        mask_d      = mask_q;
        win_d       = win_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_sat_d   = res_sat_q;
        done_d      = 1'b0;
        scan_end    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Abort in the same cycle suppresses the start entirely.
                if (cfg_start && !cfg_abort) begin
                    mask_d = cfg_mask;
                    win_d  = cfg_window;
                    if (nb_found) begin
                        cur_d   = nb_idx;
                        tmr_d   = SETTLE_LOAD;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = StSettle;
                    end else begin
                        // Empty mask: report completion without ever going busy.
                        done_d = 1'b1;
                    end
                end
            end
            StSettle: begin
                if (tmr_q == '0) begin
                    tmr_d   = gate_load;
                    state_d = StGate;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StGate: begin
                if (ro_pulse) begin
                    if (&cnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
                if (tmr_q == '0) begin
                    state_d = StLatch;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StLatch: begin
                // Oscillator is already disabled here; late pulses are dropped.
                res_data_d  = cnt_q;
                res_idx_d   = cur_q;
                res_sat_d   = sat_q;
                res_valid_d = 1'b1;
                state_d     = StPush;
            end
            StPush: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (nb_found) begin
                        cur_d   = nb_idx;
                        tmr_d   = SETTLE_LOAD;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = StSettle;
                    end else begin
                        done_d   = 1'b1;
                        scan_end = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything outside IDLE and discards a pending result.
        if (cfg_abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            res_valid_d = 1'b0;
            done_d      = 1'b1;
            scan_end    = 1'b0;
        end
    end

    // Output decode from the next state so every output comes straight off a flop.
    always_comb begin
        en_next  = (state_d == StSettle) || (state_d == StGate);
        ro_en_d  = '0;
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            ro_en_d[i] = en_next && (cur_d == IDX_W'(i));
        end
        ro_sel_d = cur_d;
        // Busy covers the final done cycle of a normal scan, but not an abort.
        busy_d   = (state_d != StIdle) || scan_end;
    end

    // State and output registers; reset drops the scan immediately.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            mask_q      <= '0;
            win_q       <= '0;
            tmr_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            ro_en_q     <= '0;
            ro_sel_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            mask_q      <= mask_d;
            win_q       <= win_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            ro_en_q     <= ro_en_d;
            ro_sel_q    <= ro_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_sat_q   <= res_sat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ro_en     = ro_en_q;
    assign ro_sel    = ro_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_sat   = res_sat_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Self-checking bench for ro_scan_ctrl (4 oscillators, 8-bit counter).
// Pulses seen at each clock edge are logged; expected counts are derived from
// that log and the documented settle/gate/latch timeline.
module tb_ro_scan_ctrl;

    localparam int S    = 4;
    localparam int MAXC = 40000;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [3:0]  cfg_mask = 4'b0;
    logic [11:0] cfg_window = 12'd0;
    logic        ro_pulse = 1'b0;
    logic        res_ready = 1'b0;
    logic [3:0]  ro_en;
    logic [1:0]  ro_sel;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_idx;
    logic        res_sat;
    logic        busy;
    logic        done;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   pmode = 0;
    logic pulse_log [0:MAXC-1];

    ro_scan_ctrl #(
        .NUM_RO     (4),
        .COUNT_W    (8),
        .WIN_W      (12),
        .SETTLE_CYC (S)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_mask   (cfg_mask),
        .cfg_window (cfg_window),
        .ro_pulse   (ro_pulse),
        .ro_en      (ro_en),
        .ro_sel     (ro_sel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .res_sat    (res_sat),
        .busy       (busy),
        .done       (done)
    );

    always #5 ACLK = ~ACLK;

    // Edge number cyc samples ro_pulse into pulse_log[cyc].
    always @(posedge ACLK) begin
        if (cyc < MAXC) pulse_log[cyc] <= ro_pulse;
        cyc <= cyc + 1;
    end

    // Pulse source: 0 none, 1 every 4th cycle, 2 random ~1/3, 3 constant high.
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            case (pmode)
                1: ro_pulse = ((cyc % 4) == 0);
                2: ro_pulse = ($urandom_range(0, 2) == 0);
                3: ro_pulse = 1'b1;
                default: ro_pulse = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Pulses seen during the gate of an oscillator whose settle began after edge t.
    function automatic int gate_pulses(input int t, input int weff);
        int n = 0;
        for (int c = t + S + 1; c <= t + S + weff; c++) n += int'(pulse_log[c]);
        return n;
    endfunction

    function automatic int next_set(input logic [3:0] m, input int from);
        for (int i = from; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Full scan of one mask; stall holds res_ready low that many cycles per result;
    // poke pulses cfg_start with a different config while busy.
    task automatic run_scan(input logic [3:0] mask, input int win, input int stall, input bit poke);
        int         t, weff, idx, n, exp_data;
        logic       exp_sat;
        logic [3:0] exp_en;
        logic [7:0] held;
        bit         more;
        weff       = (win == 0) ? 1 : win;
        cfg_mask   = mask;
        cfg_window = 12'(win);
        cfg_start  = 1'b1;
        res_ready  = (stall == 0);
        tick();
        cfg_start = 1'b0;
        t = cyc - 1;
        if (mask == 4'b0) begin
            vectors++;
            if ({done, busy, res_valid, ro_en} !== 7'b1000000) begin
                miscompares++;
                $display("FAIL mask0_done got done=%b busy=%b valid=%b en=%b exp 1 0 0 0000",
                         done, busy, res_valid, ro_en);
            end
            tick();
            vectors++;
            if ({done, busy, res_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL mask0_after got done=%b busy=%b valid=%b exp 0 0 0",
                         done, busy, res_valid);
            end
            return;
        end
        idx  = next_set(mask, 0);
        more = 1'b1;
        while (more) begin
            for (int e = t; e <= t + S + weff + 1; e++) begin
                exp_en = (e < t + S + weff) ? (4'b0001 << idx) : 4'b0000;
                vectors++;
                if (ro_en !== exp_en || busy !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_en rel=%0d en=%b busy=%b done=%b exp en=%b busy=1 done=0",
                             e - t, ro_en, busy, done, exp_en);
                end
                vectors++;
                if (res_valid !== (e == t + S + weff + 1)) begin
                    miscompares++;
                    $display("FAIL valid_timing rel=%0d got %b exp %b", e - t, res_valid,
                             (e == t + S + weff + 1));
                end
                if (e == t) begin
                    vectors++;
                    if (ro_sel !== 2'(idx)) begin
                        miscompares++;
                        $display("FAIL ro_sel got %0d exp %0d", ro_sel, idx);
                    end
                end
                if (poke && e == t + 1) begin
                    cfg_start  = 1'b1;
                    cfg_mask   = 4'b1111;
                    cfg_window = 12'd0;
                end else if (poke && e == t + 2) begin
                    cfg_start = 1'b0;
                    cfg_mask  = mask;
                end
                if (e < t + S + weff + 1) tick();
            end
            n        = gate_pulses(t, weff);
            exp_data = (n > 255) ? 255 : n;
            exp_sat  = (n > 255);
            vectors++;
            if (res_data !== 8'(exp_data) || res_idx !== 2'(idx) || res_sat !== exp_sat) begin
                miscompares++;
                $display("FAIL result got data=%0d idx=%0d sat=%b exp data=%0d idx=%0d sat=%b",
                         res_data, res_idx, res_sat, exp_data, idx, exp_sat);
            end
            held = 8'(exp_data);
            for (int k = 0; k < stall; k++) begin
                tick();
                vectors++;
                if (res_valid !== 1'b1 || res_data !== held || res_idx !== 2'(idx) ||
                    ro_en !== 4'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_hold k=%0d valid=%b data=%0d idx=%0d en=%b busy=%b exp 1 %0d %0d 0000 1",
                             k, res_valid, res_data, res_idx, ro_en, busy, held, idx);
                end
            end
            res_ready = 1'b1;
            tick();
            t = cyc - 1;
            res_ready = (stall == 0);
            idx = next_set(mask, idx + 1);
            more = (idx >= 0);
        end
        vectors++;
        if ({done, busy, res_valid, ro_en} !== 7'b1100000) begin
            miscompares++;
            $display("FAIL end_done got done=%b busy=%b valid=%b en=%b exp 1 1 0 0000",
                     done, busy, res_valid, ro_en);
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL end_idle got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        #2 ARESETN = 1'b0;
        #10;
        vectors++;
        if ({ro_en, ro_sel, res_valid, res_data, res_idx, res_sat, busy, done} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_state got en=%b sel=%0d v=%b d=%0d i=%0d s=%b b=%b dn=%b exp all 0",
                     ro_en, ro_sel, res_valid, res_data, res_idx, res_sat, busy, done);
        end
        tick();
        ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_scan_basic();
        pmode = 1;
        run_scan(4'b1011, 100, 0, 1'b0);
    endtask

    task automatic test_mask_zero();
        pmode = 2;
        run_scan(4'b0000, 10, 0, 1'b0);
        tick();
    endtask

    task automatic test_stall();
        pmode = 2;
        run_scan(4'b0101, 20, 50, 1'b0);
    endtask

    task automatic test_saturate();
        pmode = 3;
        run_scan(4'b0001, 300, 0, 1'b0);
        vectors++;
        if (res_data !== 8'hFF || res_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate got data=%h sat=%b exp ff 1", res_data, res_sat);
        end
    endtask

    task automatic test_abort();
        int w;
        bit seen;
        pmode      = 1;
        res_ready  = 1'b1;
        cfg_mask   = 4'b0011;
        cfg_window = 12'd40;
        cfg_start  = 1'b1;
        tick();
        cfg_start = 1'b0;
        w = 0;
        while (ro_en !== 4'b0010 && w < 300) begin
            tick();
            w++;
        end
        repeat (S + 3) tick();
        vectors++;
        if (ro_en !== 4'b0010) begin
            miscompares++;
            $display("FAIL abort_gate_idx1 got en=%b exp 0010", ro_en);
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        vectors++;
        if ({ro_en, res_valid, busy, done} !== 7'b0000001) begin
            miscompares++;
            $display("FAIL abort_next got en=%b valid=%b busy=%b done=%b exp 0000 0 0 1",
                     ro_en, res_valid, busy, done);
        end
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ro_en !== 4'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL abort_quiet got activity=1 exp 0");
        end
        // Abort and start together in IDLE: abort wins.
        cfg_mask  = 4'b1111;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        vectors++;
        if ({busy, ro_en, done} !== 6'b0) begin
            miscompares++;
            $display("FAIL abort_start_idle got busy=%b en=%b done=%b exp 0 0000 0", busy, ro_en, done);
        end
        run_scan(4'b0110, 10, 0, 1'b0);
    endtask

    task automatic test_reset_in_push();
        int w;
        pmode      = 1;
        res_ready  = 1'b0;
        cfg_mask   = 4'b0001;
        cfg_window = 12'd5;
        cfg_start  = 1'b1;
        tick();
        cfg_start = 1'b0;
        w = 0;
        while (res_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        vectors++;
        if (res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL push_reach got valid=%b exp 1", res_valid);
        end
        #3 ARESETN = 1'b0;
        #1;
        vectors++;
        if ({ro_en, ro_sel, res_valid, res_data, res_idx, res_sat, busy, done} !== 20'h0) begin
            miscompares++;
            $display("FAIL async_reset got en=%b sel=%0d v=%b d=%0d i=%0d s=%b b=%b dn=%b exp all 0",
                     ro_en, ro_sel, res_valid, res_data, res_idx, res_sat, busy, done);
        end
        tick();
        ARESETN = 1'b1;
        tick();
        vectors++;
        if ({busy, res_valid, ro_en} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_release got busy=%b valid=%b en=%b exp 0 0 0000", busy, res_valid, ro_en);
        end
    endtask

    task automatic test_start_busy_win0();
        pmode = 3;
        run_scan(4'b1101, 0, 0, 1'b1);
        pmode = 2;
        run_scan(4'b0010, 7, 2, 1'b1);
    endtask

    task automatic test_random();
        repeat (10) begin
            pmode = $urandom_range(0, 3);
            run_scan(4'($urandom_range(0, 15)), $urandom_range(0, 40),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
                     1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_mask_zero();
        test_stall();
        test_saturate();
        test_abort();
        test_reset_in_push();
        test_start_busy_win0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
